// File: rtl/multi_breath_pwm.sv
// Multi-channel breathing-LED PWM engine: triangle brightness ramp per channel, OFF/ON/BREATHE/FIXED.
// Optional build macro PHASE_SPREAD_EN staggers the reset position of each channel along the triangle.
module multi_breath_pwm #(
  parameter int unsigned CH       = 4,
  parameter int unsigned PWM_W    = 12,
  parameter int unsigned STEP_PER = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2*CH-1:0]    mode,
  input  logic [PWM_W-1:0]   fix_duty,
  output logic [CH-1:0]      led_ctl,
  output logic               step_tick
);

  localparam int unsigned     MaxI    = (2 ** PWM_W) - 1;
  localparam logic [PWM_W-1:0] Max    = '1;
  localparam int unsigned     PreW    = (STEP_PER > 1) ? $clog2(STEP_PER) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(STEP_PER - 1);

`ifdef PHASE_SPREAD_EN
  localparam bit Spread = 1'b1;
`else
  localparam bit Spread = 1'b0;
`endif

  localparam logic [1:0] ModeOff   = 2'b00;
  localparam logic [1:0] ModeOn    = 2'b01;
  localparam logic [1:0] ModeFixed = 2'b11;

  // Position of channel i along the 0..2*MAX triangle at reset.
  function automatic int unsigned rst_pos(int unsigned i);
    return Spread ? (i * 2 * MaxI) / CH : 0;
  endfunction

  function automatic logic [PWM_W-1:0] rst_level(int unsigned i);
    int unsigned p;
    p = rst_pos(i);
    return (p <= MaxI) ? PWM_W'(p) : PWM_W'(2 * MaxI - p);
  endfunction

  function automatic logic rst_down(int unsigned i);
    return rst_pos(i) >= MaxI;
  endfunction

  logic [PWM_W-1:0]          cnt_q, cnt_d;
  logic [PreW-1:0]           pre_q, pre_d;
  logic [CH-1:0][PWM_W-1:0]  level_q, level_d;
  logic [CH-1:0][PWM_W-1:0]  duty_q, duty_d;
  logic [CH-1:0]             dir_q, dir_d;  // 1 = ramping down
  logic [CH-1:0]             led_d;
  logic                      wrap, step;

  always_comb begin
    wrap    = en && (cnt_q == Max);
    step    = wrap && (pre_q == PreLast);
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    level_d = level_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    led_d   = '0;

    if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (wrap) begin
      pre_d = step ? '0 : pre_q + 1'b1;
    end

    for (int unsigned i = 0; i < CH; i++) begin
      if (step) begin
        if (!dir_q[i]) begin
          level_d[i] = level_q[i] + 1'b1;
          if (level_q[i] == Max - 1'b1) dir_d[i] = 1'b1;
        end else begin
          level_d[i] = level_q[i] - 1'b1;
          if (level_q[i] == PWM_W'(1)) dir_d[i] = 1'b0;
        end
      end
      // Latch duty at the frame boundary so mid-frame changes never glitch the output.
      if (wrap) begin
        duty_d[i] = (mode[2*i +: 2] == ModeFixed) ? fix_duty : level_q[i];
      end
      if (en) begin
        case (mode[2*i +: 2])
          ModeOff: led_d[i] = 1'b0;
          ModeOn:  led_d[i] = 1'b1;
          default: led_d[i] = (cnt_q < duty_q[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pre_q     <= '0;
      duty_q    <= '0;
      led_ctl   <= '0;
      step_tick <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        level_q[i] <= rst_level(i);
        dir_q[i]   <= rst_down(i);
      end
    end else begin
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      level_q   <= level_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
      led_ctl   <= led_d;
      step_tick <= step;
    end
  end

endmodule

// File: tb/tb_multi_breath_pwm.sv
// Randomized bench for multi_breath_pwm: two instances (STEP_PER 1 and 3) against a triangle-position model.
module tb_multi_breath_pwm;

  localparam int W   = 4;
  localparam int CH  = 4;
  localparam int MAX = 15;

`ifdef PHASE_SPREAD_EN
  localparam bit SPREAD = 1'b1;
`else
  localparam bit SPREAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2*CH-1:0] mode;
  logic [W-1:0]  fix_duty;
  logic [CH-1:0] led_a, led_b;
  logic          tick_a, tick_b;

  always #5 clk = ~clk;

  multi_breath_pwm #(.CH(CH), .PWM_W(W), .STEP_PER(1)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fix_duty(fix_duty),
    .led_ctl(led_a), .step_tick(tick_a)
  );

  multi_breath_pwm #(.CH(CH), .PWM_W(W), .STEP_PER(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fix_duty(fix_duty),
    .led_ctl(led_b), .step_tick(tick_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: each channel is a position along a 2*MAX-long triangle; level is derived from it.
  int            sp[2] = '{1, 3};
  int            m_cnt[2];
  int            m_pre[2];
  int            m_pos[2][CH];
  int            m_duty[2][CH];
  logic [CH-1:0] m_led[2];
  logic          m_tick[2];

  int  cyc = 0;
  bit  spacing_on = 1'b0;
  int  tick_last[2] = '{-1, -1};

  function automatic int lvl(input int pos);
    return (pos <= MAX) ? pos : 2 * MAX - pos;
  endfunction

  function automatic int rst_pos(input int i);
    return SPREAD ? (i * 2 * MAX) / CH : 0;
  endfunction

  task automatic model_step(input int k);
    logic [1:0] md;
    bit wrap, stp;
    if (rst) begin
      m_cnt[k]  = 0;
      m_pre[k]  = 0;
      m_led[k]  = '0;
      m_tick[k] = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_pos[k][i]  = rst_pos(i);
        m_duty[k][i] = 0;
      end
    end else if (!en) begin
      m_led[k]  = '0;
      m_tick[k] = 1'b0;
    end else begin
      wrap = (m_cnt[k] == MAX);
      stp  = wrap && (m_pre[k] == sp[k] - 1);
      for (int i = 0; i < CH; i++) begin
        md = mode[2*i +: 2];
        if (md == 2'b00)      m_led[k][i] = 1'b0;
        else if (md == 2'b01) m_led[k][i] = 1'b1;
        else                  m_led[k][i] = (m_cnt[k] < m_duty[k][i]);
        if (wrap) begin
          m_duty[k][i] = (md == 2'b11) ? int'(fix_duty) : lvl(m_pos[k][i]);
          if (stp) m_pos[k][i] = (m_pos[k][i] + 1) % (2 * MAX);
        end
      end
      if (wrap) m_pre[k] = (m_pre[k] + 1) % sp[k];
      m_cnt[k]  = (m_cnt[k] + 1) % (MAX + 1);
      m_tick[k] = stp;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    model_step(0);
    model_step(1);
    check("led_sp1", 32'(led_a), 32'(m_led[0]));
    check("tick_sp1", 32'(tick_a), 32'(m_tick[0]));
    check("led_sp3", 32'(led_b), 32'(m_led[1]));
    check("tick_sp3", 32'(tick_b), 32'(m_tick[1]));
    if (spacing_on) begin
      if (tick_a) begin
        if (tick_last[0] >= 0) check("spacing_sp1", 32'(cyc - tick_last[0]), 32'd16);
        tick_last[0] = cyc;
      end
      if (tick_b) begin
        if (tick_last[1] >= 0) check("spacing_sp3", 32'(cyc - tick_last[1]), 32'd48);
        tick_last[1] = cyc;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    mode     = '0;
    fix_duty = '0;
    cycle();
    cycle();
    check("rst_led", 32'({led_b, led_a}), 32'd0);
    check("rst_tick", 32'({tick_b, tick_a}), 32'd0);
    rst = 1'b0;

    // All OFF: outputs stay low while step_tick keeps pulsing.
    repeat (40) cycle();

    // ch0 BREATHE through a full breath with tick spacing checked.
    mode       = 8'b00_00_00_10;
    spacing_on = 1'b1;
    repeat (560) cycle();
    spacing_on = 1'b0;

    // ch1 FIXED with fix_duty moved at random points mid-frame.
    mode     = 8'b00_00_11_10;
    fix_duty = 4'd5;
    repeat (200) begin
      cycle();
      if ($urandom_range(0, 19) == 0) fix_duty = 4'($urandom);
    end

    // Mid-frame pause, resume, then reset mid-breath.
    while (m_cnt[0] != 7) cycle();
    en = 1'b0;
    repeat (40) cycle();
    en = 1'b1;
    repeat (50) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_led", 32'({led_b, led_a}), 32'd0);
    rst = 1'b0;

    // All channels breathing (staggered when phase spread is built in).
    mode = 8'b10_10_10_10;
    repeat (600) cycle();

    // Random traffic on every input.
    repeat (3000) begin
      cycle();
      if ($urandom_range(0, 63) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 15) == 0) fix_duty = 4'($urandom);
      if ($urandom_range(0, 31) == 0) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
